fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Ports, one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard-unit hold of IF/ID
- redir_valid  in  1  EX-resolved taken branch/JAL/JALR
- redir_target  in  32  redirect address
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_gnt  in  1  memory accepts request
- imem_rvalid  in  1  instruction word valid
- imem_rdata  in  32  instruction word
- if_valid  out  1  instruction presented to ID
- if_pc  out  32  PC of presented instruction
- if_instr  out  32  presented instruction
- flush_ifid  out  1  kill IF/ID contents
- flush_idex  out  1  kill ID/EX contents
- misalign_trap  out  1  misaligned redirect pulse

Function
REQ-003 States: FETCH, WAIT, HOLD, DRAIN, HALT; at most one memory request outstanding.
REQ-004 FETCH: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT.
REQ-005 WAIT: imem_req=0; on imem_rvalid, capture imem_rdata and pc into output register -> HOLD.
REQ-006 HOLD: if_valid=1, if_pc/if_instr stable; consumed in a cycle with stall=0; on consume pc<=pc+4 (mod 2^32) -> FETCH.
REQ-007 While stall=1 in HOLD, no output or pc change; stall ignored in FETCH/WAIT.
REQ-008 Minimum latency: gnt in cycle N, rvalid in N+1, if_valid from N+2; peak throughput 1 instruction / 3 cycles.
REQ-009 Redirect priority over stall, gnt, rvalid: on redir_valid, pc<=redir_target next edge; flush_ifid=flush_idex=1 combinationally same cycle; if_valid=0 from next cycle.
REQ-010 Redirect next state: from WAIT without rvalid, or FETCH with gnt in the same cycle -> DRAIN; otherwise -> FETCH.
REQ-011 WAIT + redirect + rvalid same cycle: response discarded -> FETCH.
REQ-012 DRAIN: imem_req=0; next rvalid discarded -> FETCH; redirect in DRAIN updates pc, stays DRAIN unless rvalid same cycle (-> FETCH).
REQ-013 flush outputs are single-cycle, 0 when redir_valid=0; if_valid=0 in FETCH, WAIT, DRAIN, HALT.
REQ-014 HALT: imem_req=0, if_valid=0, exited only by rst.

Reset
REQ-015 rst=1: state FETCH, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), flush_*=0, misalign_trap=0; an outstanding response after reset is ignored (state already FETCH, rvalid not expected).
REQ-016 rst dominates redir_valid and all other inputs.

Configuration
REQ-017 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redir_target[1:0]!=0 -> misalign_trap=1 one cycle, flushes asserted, pc unchanged, state -> HALT.
REQ-018 Macro undefined: misalign_trap tied 0; redir_target[1:0] forced to 2'b00; HALT unreachable.

Structure
REQ-019 Shared package/include (alongside ctrl_encode_def.v): state encodings, RESET_PC default, NOP constant 32'h0000_0013.
REQ-020 One sub-module, fetch_hold_reg: if_pc/if_instr/if_valid output register with load, hold, clear.

Verification
REQ-021 Reset RESET_PC=0x100, gnt and rvalid always 1 -> imem_addr 0x100, 0x104, 0x108; if_valid every 3rd cycle with matching if_pc.
REQ-022 stall=1 for 5 cycles in HOLD at if_pc=0x104 -> if_pc/if_instr stable, imem_req=0, next imem_addr 0x108 after release.
REQ-023 Redirect to 0x200 in WAIT, rvalid one cycle later -> flush pulse, that response dropped, next imem_addr 0x200, next if_pc 0x200.
REQ-024 redir_valid with stall=1 in HOLD, target 0x300 -> flush pulse, if_valid=0 next cycle, next fetch 0x300.
REQ-025 Target 0x402: macro defined -> misalign_trap pulse, imem_req stays 0 until rst; macro undefined -> fetch 0x400.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: state encodings,
// reset PC default and the NOP word presented after reset.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// IF/ID output register: loads a fetched word with its PC, holds it while
// stalled, and clears only the valid flag when the word is consumed or killed.
module fetch_hold_reg
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    // Presented instruction register with load > clear > hold priority
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= NOP_INSTR;
        end else if (load) begin
            if_valid <= 1'b1;
            if_pc    <= ld_pc;
            if_instr <= ld_instr;
        end else if (clear) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller with EX redirect handling.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirects trap and halt fetch.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misalign_trap
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  target_s;
    logic         misalign_s;
    logic         load_s, clear_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_s   = redir_target;
    assign misalign_s = (redir_target[1:0] != 2'b00);
`else
    assign target_s   = redir_target & 32'hFFFF_FFFC;
    assign misalign_s = 1'b0;
`endif

    // State and PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Next-state, next-PC and output-register control
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        if (redir_valid) begin
            clear_s = 1'b1;
            if (state_r == ST_HALT) begin
                state_nxt_s = ST_HALT;
            end else if (misalign_s) begin
                state_nxt_s = ST_HALT;
            end else begin
                pc_nxt_s = target_s;
                // A request already in flight must have its response drained
                case (state_r)
                    ST_FETCH:         state_nxt_s = imem_gnt ? ST_DRAIN : ST_FETCH;
                    ST_WAIT, ST_DRAIN: state_nxt_s = imem_rvalid ? ST_FETCH : ST_DRAIN;
                    default:          state_nxt_s = ST_FETCH;
                endcase
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_gnt) state_nxt_s = ST_WAIT;
                    else          state_nxt_s = ST_FETCH;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_nxt_s = ST_HOLD;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_nxt_s = ST_FETCH;
                        pc_nxt_s    = pc_next_seq(pc_r);
                        clear_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) state_nxt_s = ST_FETCH;
                    else             state_nxt_s = ST_DRAIN;
                end
                ST_HALT:  state_nxt_s = ST_HALT;
                default:  state_nxt_s = ST_FETCH;
            endcase
        end
    end

    // Memory request and same-cycle flush/trap outputs
    always_comb begin
        imem_req      = (state_r == ST_FETCH);
        imem_addr     = pc_r;
        flush_ifid    = redir_valid & ~rst;
        flush_idex    = redir_valid & ~rst;
        misalign_trap = redir_valid & misalign_s & ~rst & (state_r != ST_HALT);
    end

    fetch_hold_reg u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .clear    (clear_s),
        .ld_pc    (pc_r),
        .ld_instr (imem_rdata),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a transaction-level model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misalign_trap;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    // Model: a PC, whether a word is held for ID, whether a request is in
    // flight and whether its response is to be thrown away, and a halt flag.
    logic [31:0] m_pc, m_opc, m_oinstr;
    bit m_have, m_pend, m_drop, m_halt, m_ok;

    // Snapshot of DUT outputs taken at the checking point of each step
    logic        s_req, s_valid, s_fl, s_fi, s_trap;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update();
        bit req;
        if (rst) begin
            m_pc = 32'h0000_0100; m_have = 0; m_pend = 0; m_drop = 0; m_halt = 0;
            m_opc = 32'h0; m_oinstr = 32'h0000_0013; m_ok = 1;
        end else if (!m_halt) begin
            req = !m_have && !m_pend;
            if (redir_valid) begin
                if (mis(redir_target)) begin
                    m_halt = 1; m_have = 0; m_pend = 0; m_drop = 0;
                end else begin
                    m_pc = {redir_target[31:2], 2'b00};
                    m_have = 0;
                    if (req && imem_gnt) begin
                        m_pend = 1; m_drop = 1;
                    end else if (m_pend) begin
                        if (imem_rvalid) begin m_pend = 0; m_drop = 0; end
                        else m_drop = 1;
                    end
                end
            end else if (req && imem_gnt) begin
                m_pend = 1; m_drop = 0;
            end else if (m_pend && imem_rvalid) begin
                m_pend = 0;
                if (!m_drop) begin m_have = 1; m_opc = m_pc; m_oinstr = imem_rdata; end
                m_drop = 0;
            end else if (m_have && !stall) begin
                m_have = 0; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_model();
        chk("req",    {31'b0, imem_req}, {31'b0, !m_halt && !m_have && !m_pend});
        chk("addr",   imem_addr, m_pc);
        chk("valid",  {31'b0, if_valid}, {31'b0, m_have});
        chk("if_pc",  if_pc, m_opc);
        chk("instr",  if_instr, m_oinstr);
        chk("flush",  {30'b0, flush_ifid, flush_idex}, {30'b0, redir_valid, redir_valid});
        chk("trap",   {31'b0, misalign_trap}, {31'b0, redir_valid && mis(redir_target) && !m_halt});
    endtask

    task automatic step(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                        input bit g, input bit rvl, input logic [31:0] rd);
        @(negedge clk);
        rst = r; stall = st; redir_valid = rv; redir_target = rt;
        imem_gnt = g; imem_rvalid = rvl; imem_rdata = rd;
        #1;
        if (m_ok && !r) compare_model();
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_pc = if_pc;
        s_instr = if_instr; s_fl = flush_ifid; s_fi = flush_idex; s_trap = misalign_trap;
        @(posedge clk);
        model_update();
    endtask

    initial begin
        m_ok = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        // Reset values and first fetch from RESET_PC
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("rst_req", {31'b0, s_req}, 32'd1);
        chk("rst_addr", s_addr, 32'h0000_0100);
        chk("rst_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_pc", s_pc, 32'h0);
        chk("rst_instr", s_instr, 32'h0000_0013);
        chk("rst_flush", {30'b0, s_fl, s_fi}, 32'd0);
        chk("rst_trap", {31'b0, s_trap}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h1111_0100);
        chk("wait_req", {31'b0, s_req}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("hold1_valid", {31'b0, s_valid}, 32'd1);
        chk("hold1_pc", s_pc, 32'h0000_0100);
        chk("hold1_instr", s_instr, 32'h1111_0100);
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("f2_addr", s_addr, 32'h0000_0104);
        chk("f2_req", {31'b0, s_req}, 32'd1);
        step(0, 0, 0, 0, 1, 1, 32'h2222_0104);
        // Five stalled cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 1, 1, $urandom);
            chk("stall_valid", {31'b0, s_valid}, 32'd1);
            chk("stall_pc", s_pc, 32'h0000_0104);
            chk("stall_instr", s_instr, 32'h2222_0104);
            chk("stall_req", {31'b0, s_req}, 32'd0);
        end
        step(0, 0, 0, 0, 1, 1, 32'h0);
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("f3_addr", s_addr, 32'h0000_0108);
        // Redirect while waiting; late response is dropped
        step(0, 0, 1, 32'h0000_0200, 1, 0, 32'h0);
        chk("rw_flush", {30'b0, s_fl, s_fi}, 32'd3);
        step(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("drain_req", {31'b0, s_req}, 32'd0);
        chk("drain_valid", {31'b0, s_valid}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("rw_addr", s_addr, 32'h0000_0200);
        chk("rw_req", {31'b0, s_req}, 32'd1);
        step(0, 0, 0, 0, 1, 1, 32'h3333_0200);
        // Redirect beats stall in HOLD
        step(0, 1, 1, 32'h0000_0300, 1, 1, 32'h0);
        chk("rh_pc", s_pc, 32'h0000_0200);
        chk("rh_instr", s_instr, 32'h3333_0200);
        chk("rh_flush", {30'b0, s_fl, s_fi}, 32'd3);
        // Misaligned redirect from FETCH
        step(0, 0, 1, 32'h0000_0402, 0, 0, 32'h0);
        chk("rh_valid", {31'b0, s_valid}, 32'd0);
        chk("rh_addr", s_addr, 32'h0000_0300);
        chk("mis_flush", {30'b0, s_fl, s_fi}, 32'd3);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_trap", {31'b0, s_trap}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 1, 32'h0);
            chk("halt_req", {31'b0, s_req}, 32'd0);
            chk("halt_trap", {31'b0, s_trap}, 32'd0);
        end
`else
        chk("mis_trap", {31'b0, s_trap}, 32'd0);
        step(0, 0, 0, 0, 1, 1, 32'h0);
        chk("mis_addr", s_addr, 32'h0000_0400);
        chk("mis_req", {31'b0, s_req}, 32'd1);
`endif
        step(1, 0, 0, 0, 0, 0, 32'h0);
        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, rt,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
